// File: rtl/argmax_pkg.sv
// Shared defaults, score/index types and FSM state encoding
// for the pooled-score argmax block.
package argmax_pkg;

  localparam int NUM_CLASSES_DEF = 8;
  localparam int DATA_W_DEF      = 16;
  localparam int IDX_W_DEF       = $clog2(NUM_CLASSES_DEF);

  typedef logic [IDX_W_DEF-1:0]         class_idx_t;
  typedef logic signed [DATA_W_DEF-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

endpackage

// File: rtl/argmax_cmp.sv
// Signed strict-greater compare and select of one candidate
// against the running best; ties keep the incumbent.
module argmax_cmp
  import argmax_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic [DATA_W-1:0] cand,
  input  logic [IDX_W-1:0]  cand_idx,
  input  logic [DATA_W-1:0] best,
  input  logic [IDX_W-1:0]  best_idx,
  output logic [DATA_W-1:0] win_score,
  output logic [IDX_W-1:0]  win_idx
);

  logic gt;

  assign gt        = $signed(cand) > $signed(best);
  assign win_score = gt ? cand : best;
  assign win_idx   = gt ? cand_idx : best_idx;

endmodule

// File: rtl/pool_argmax.sv
// Sequential argmax over pooled class scores, one class per cycle.
// Define ARGMAX_SCORE_OUT_EN to expose the winning score on max_score.
module pool_argmax
  import argmax_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [DATA_W-1:0]              scores [NUM_CLASSES],
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_CLASSES)-1:0] class_idx
`ifdef ARGMAX_SCORE_OUT_EN
  ,
  output logic [DATA_W-1:0]              max_score
`endif
);

  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam int CNT_W = IDX_W + 1;

  state_e state_q, state_d;

  logic [DATA_W-1:0] bank [NUM_CLASSES];
  logic [DATA_W-1:0] best_q;
  logic [IDX_W-1:0]  best_idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] win_score;
  logic [IDX_W-1:0]  win_idx;
  logic              last;

  assign last = cnt_q == CNT_W'(NUM_CLASSES - 1);
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;

  argmax_cmp #(
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_cmp (
    .cand     (bank[cnt_q[IDX_W-1:0]]),
    .cand_idx (cnt_q[IDX_W-1:0]),
    .best     (best_q),
    .best_idx (best_idx_q),
    .win_score(win_score),
    .win_idx  (win_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scores are captured once; later input changes cannot disturb a scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) bank[i] <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      class_idx  <= '0;
`ifdef ARGMAX_SCORE_OUT_EN
      max_score  <= '0;
`endif
    end else if (state_q == IDLE && start) begin
      bank       <= scores;
      best_q     <= scores[0];
      best_idx_q <= '0;
      cnt_q      <= CNT_W'(1);
    end else if (state_q == SCAN) begin
      best_q     <= win_score;
      best_idx_q <= win_idx;
      cnt_q      <= cnt_q + CNT_W'(1);
      if (last) begin
        class_idx <= win_idx;
`ifdef ARGMAX_SCORE_OUT_EN
        max_score <= win_score;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pool_argmax.sv
// Directed and randomized bench for pool_argmax against an
// array-based argmax reference.
module tb_pool_argmax;

  localparam int NC = 8;
  localparam int DW = 16;

  typedef logic [DW-1:0] vec_t [NC];

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  vec_t       scores;
  logic       busy;
  logic       done;
  logic [2:0] class_idx;
`ifdef ARGMAX_SCORE_OUT_EN
  logic [DW-1:0] max_score;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pool_argmax #(
    .NUM_CLASSES(NC),
    .DATA_W     (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .scores   (scores),
    .busy     (busy),
    .done     (done),
    .class_idx(class_idx)
`ifdef ARGMAX_SCORE_OUT_EN
    ,
    .max_score(max_score)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int c,
                              input int d, input int e, input int f,
                              input int g, input int h);
    vec_t v;
    v[0] = 16'(a); v[1] = 16'(b); v[2] = 16'(c); v[3] = 16'(d);
    v[4] = 16'(e); v[5] = 16'(f); v[6] = 16'(g); v[7] = 16'(h);
    return v;
  endfunction

  function automatic int ref_max(input vec_t v);
    int mx = -32768;
    for (int i = 0; i < NC; i++)
      if (int'($signed(v[i])) > mx) mx = int'($signed(v[i]));
    return mx;
  endfunction

  // First index holding the maximum value.
  function automatic int ref_idx(input vec_t v);
    int mx = ref_max(v);
    for (int i = 0; i < NC; i++)
      if (int'($signed(v[i])) == mx) return i;
    return -1;
  endfunction

  function automatic vec_t rnd_vec(input bit narrow);
    vec_t v;
    for (int i = 0; i < NC; i++)
      v[i] = narrow ? 16'(int'($urandom_range(0, 4)) - 2)
                    : 16'($urandom_range(0, 65535));
    return v;
  endfunction

  task automatic do_start(input vec_t v);
    scores = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    scores = rnd_vec(1'b0);
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(input string tag, input vec_t v, input int exp_lat);
    int lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_idx"}, int'(class_idx), ref_idx(v));
`ifdef ARGMAX_SCORE_OUT_EN
    chk({tag, "_max"}, int'($signed(max_score)), ref_max(v));
`endif
    @(negedge clk);
    chk({tag, "_done_drop"}, int'(done), 0);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic run(input string tag, input vec_t v);
    do_start(v);
    wait_done(tag, v, NC - 1);
  endtask

  initial begin
    vec_t v;
    int   extra;
    int   held;

    rst    = 1'b1;
    start  = 1'b0;
    scores = mk(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_idx", int'(class_idx), 0);
`ifdef ARGMAX_SCORE_OUT_EN
    chk("reset_max", int'(max_score), 0);
`endif

    v = mk(5, -3, 12, 7, 0, 12, -1, 2);
    run("tie_low", v);
    chk("tie_low_fixed", int'(class_idx), 2);

    held = int'(class_idx);
    repeat (4) begin
      scores = rnd_vec(1'b0);
      start  = 1'b0;
      @(negedge clk);
    end
    chk("hold_idx", int'(class_idx), held);

    run("all_min", mk(-32768, -32768, -32768, -32768,
                      -32768, -32768, -32768, -32768));
    run("all_max", mk(32767, 32767, 32767, 32767,
                      32767, 32767, 32767, 32767));
    v = mk(-5, -4, -3, -2, -1, -6, -7, -8);
    run("signed", v);
    chk("signed_fixed", int'(class_idx), 4);

    v = mk(1, 2, 3, 40, 5, 6, 7, 8);
    do_start(v);
    repeat (2) @(negedge clk);
    start  = 1'b1;
    scores = mk(0, 0, 0, 0, 0, 0, 900, 0);
    @(negedge clk);
    start  = 1'b0;
    wait_done("restart_ign", v, NC - 4);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("restart_no_rerun", extra, 0);

    do_start(mk(0, 0, 0, 0, 0, 9, 0, 0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_idx", int'(class_idx), 0);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("abort_no_done", extra, 0);

    run("post_abort", mk(3, 1, 4, 1, 5, 9, 2, 6));
    run("b2b", mk(-1, 100, -100, 100, 50, 0, 7, 99));

    for (int k = 0; k < 24; k++) begin
      v = rnd_vec(k[0]);
      run($sformatf("rand%0d", k), v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
